// File: rtl/sc_sched_pkg.sv
// Shared definitions for the stochastic-multiplier round-robin scheduler.
//   sched_state_e : scheduler FSM states (IDLE, CALC, RESP)
//   SC_VAL_W      : operand width of the SC_Mul_8 core
//   SC_RES_W      : result width of the SC_Mul_8 core
package sc_sched_pkg;
  localparam int SC_VAL_W = 5;
  localparam int SC_RES_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } sched_state_e;
endpackage

// File: rtl/SC_Mul_8.sv
// Combinational 5-bit stochastic multiplier core (expected-value model).
// The product of the two 5-bit magnitudes is scaled down to the 1..16
// result code: sc_result = floor(in_a * in_b / 64) + 1.
//   in_a, in_b : 5-bit operands
//   sc_result  : 5-bit result code, range 1..16
module SC_Mul_8 (
  input  logic [4:0] in_a,
  input  logic [4:0] in_b,
  output logic [4:0] sc_result
);
  logic [9:0] prod;

  assign prod      = {5'd0, in_a} * {5'd0, in_b};
  assign sc_result = 5'(prod >> 6) + 5'd1;
endmodule

// File: rtl/sc_mul_rr_sched_rr_arbiter.sv
// Combinational round-robin arbiter.
// Search starts one position above rr_ptr and wraps; the first set req bit
// wins. With en low no grant is produced.
//   req    : request vector
//   rr_ptr : index of the most recent winner
//   en     : arbitration enable
//   gnt    : one-hot grant (or zero)
//   gnt_id : binary index of the granted requester (0 when no grant)
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id
);
  logic [ID_W-1:0] idx;
  logic            found;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    idx    = '0;
    found  = 1'b0;
    if (en) begin
      // k = NUM_REQ revisits rr_ptr itself, so the last winner is served
      // again only when it is the sole requester.
      for (int k = 1; k <= NUM_REQ; k++) begin
        idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
        if (!found && req[idx]) begin
          found    = 1'b1;
          gnt[idx] = 1'b1;
          gnt_id   = idx;
        end
      end
    end
  end
endmodule

// File: rtl/sc_mul_rr_sched.sv
// Round-robin scheduler sharing one SC_Mul_8 core among NUM_REQ requesters.
// One operation in flight: IDLE (arbitrate/accept) -> CALC (operand regs
// drive the core, result registered) -> RESP (hold result until accepted).
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/req_ready : per-requester handshake (ready is one-hot or zero)
//   req_a, req_b        : packed operands, requester i at [i*VAL_W +: VAL_W]
//   rsp_valid/rsp_ready : response handshake
//   rsp_id, rsp_data    : requester tag and core result
//   busy                : high outside IDLE
module sc_mul_rr_sched
  import sc_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int VAL_W   = SC_VAL_W,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*VAL_W-1:0] req_a,
  input  logic [NUM_REQ*VAL_W-1:0] req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [SC_RES_W-1:0]      rsp_data,
  output logic                     busy
);
  sched_state_e          state_q, state_d;
  logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [VAL_W-1:0]      a_q, a_d;
  logic [VAL_W-1:0]      b_q, b_d;
  logic [ID_W-1:0]       id_q, id_d;
  logic [SC_RES_W-1:0]   data_q, data_d;

  logic [VAL_W-1:0]      a_lane [NUM_REQ];
  logic [VAL_W-1:0]      b_lane [NUM_REQ];
  logic [NUM_REQ-1:0]    gnt;
  logic [ID_W-1:0]       gnt_id;
  logic                  arb_en;
  logic [SC_RES_W-1:0]   core_res;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
      assign a_lane[gi] = req_a[gi*VAL_W +: VAL_W];
      assign b_lane[gi] = req_b[gi*VAL_W +: VAL_W];
    end
  endgenerate

  // Enable depends on the state register only, keeping the grant path
  // free of any loop through the next-state logic.
  assign arb_en = (state_q == IDLE);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req    (req_valid),
    .rr_ptr (rr_ptr_q),
    .en     (arb_en),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  SC_Mul_8 u_core (
    .in_a      (a_q),
    .in_b      (b_q),
    .sc_result (core_res)
  );

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    a_d      = a_q;
    b_d      = b_q;
    id_d     = id_q;
    data_d   = data_q;
    case (state_q)
      IDLE: begin
        if (|gnt) begin
          a_d      = a_lane[gnt_id];
          b_d      = b_lane[gnt_id];
          id_d     = gnt_id;
          rr_ptr_d = gnt_id;
          state_d  = CALC;
        end
      end
      CALC: begin
        data_d  = core_res;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= ID_W'(NUM_REQ - 1);
      a_q      <= '0;
      b_q      <= '0;
      id_q     <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      a_q      <= a_d;
      b_q      <= b_d;
      id_q     <= id_d;
      data_q   <= data_d;
    end
  end

  assign req_ready = gnt;
  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = id_q;
  assign rsp_data  = data_q;
  assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_sc_mul_rr_sched.sv
module tb_sc_mul_rr_sched;
  localparam int N  = 4;
  localparam int VW = 5;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*VW-1:0] req_a = '0;
  logic [N*VW-1:0] req_b = '0;
  logic [N-1:0]    req_ready;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [IW-1:0]   rsp_id;
  logic [4:0]      rsp_data;
  logic            busy;

  always #5 clk = ~clk;

  sc_mul_rr_sched #(.NUM_REQ(N), .VAL_W(VW), .ID_W(IW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
  );

  typedef struct packed { logic [IW-1:0] id; logic [4:0] data; } sb_t;
  typedef struct { logic [N-1:0] valid; logic [N-1:0] exp_gnt; int exp_id; } vec_t;
  typedef enum logic [1:0] { M_IDLE, M_CALC, M_RESP } m_state_t;

  sb_t       sb_q[$];
  vec_t      tbl[12];
  m_state_t  m_state = M_IDLE;
  int        m_ptr = N - 1;
  logic [N-1:0] last_gnt = '0;
  int        grant_cnt[N];
  int        rsp_cnt[N];
  int        gnt_log_id[$];
  int        gnt_log_cyc[$];
  int        n_cmp = 0, n_fail = 0, cyc = 0, rsp_total = 0;
  logic [4:0] bp_a, bp_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [4:0] golden(input logic [4:0] a, input logic [4:0] b);
    int p;
    p = int'(a) * int'(b);
    return 5'(p / 64 + 1);
  endfunction

  function automatic logic [N-1:0] rr_model(input logic [N-1:0] v, input int ptr);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (ptr + k) % N;
      if (v[idx]) return N'(1) << idx;
    end
    return '0;
  endfunction

  task automatic set_op(input int i, input logic [4:0] a, input logic [4:0] b);
    req_a[i*VW +: VW] = a;
    req_b[i*VW +: VW] = b;
  endtask

  // Reference model and scoreboard, evaluated mid-cycle on the falling edge.
  task automatic mon();
    logic [N-1:0] eg;
    int id;
    sb_t e;
    last_gnt = '0;
    if (rst) begin
      m_state = M_IDLE;
      m_ptr   = N - 1;
      sb_q.delete();
      for (int i = 0; i < N; i++) begin
        grant_cnt[i] = 0;
        rsp_cnt[i]   = 0;
      end
      return;
    end
    case (m_state)
      M_IDLE: begin
        chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        eg = rr_model(req_valid, m_ptr);
        chk("model_gnt", 32'(req_ready), 32'(eg));
        if (eg != '0) begin
          id = 0;
          for (int i = 0; i < N; i++) if (eg[i]) id = i;
          e.id   = IW'(id);
          e.data = golden(req_a[id*VW +: VW], req_b[id*VW +: VW]);
          sb_q.push_back(e);
          grant_cnt[id]++;
          m_ptr    = id;
          m_state  = M_CALC;
          last_gnt = eg;
          gnt_log_id.push_back(id);
          gnt_log_cyc.push_back(cyc);
        end
      end
      M_CALC: begin
        chk("calc_req_ready", 32'(req_ready), 32'd0);
        chk("calc_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("calc_busy", 32'(busy), 32'd1);
        m_state = M_RESP;
      end
      default: begin
        chk("resp_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("resp_req_ready", 32'(req_ready), 32'd0);
        chk("resp_busy", 32'(busy), 32'd1);
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL sb_underflow: response with empty scoreboard (cycle %0d)", cyc);
        end else begin
          e = sb_q[0];
          chk("rsp_id", 32'(rsp_id), 32'(e.id));
          chk("rsp_data", 32'(rsp_data), 32'(e.data));
          if (rsp_ready) begin
            void'(sb_q.pop_front());
            rsp_cnt[int'(e.id)]++;
            rsp_total++;
            m_state = M_IDLE;
          end
        end
      end
    endcase
  endtask

  task automatic tick();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    tbl[0]  = '{4'b0001, 4'b0001, 0};
    tbl[1]  = '{4'b1111, 4'b0010, 1};
    tbl[2]  = '{4'b1111, 4'b0100, 2};
    tbl[3]  = '{4'b1111, 4'b1000, 3};
    tbl[4]  = '{4'b1111, 4'b0001, 0};
    tbl[5]  = '{4'b1010, 4'b0010, 1};
    tbl[6]  = '{4'b1010, 4'b1000, 3};
    tbl[7]  = '{4'b0011, 4'b0001, 0};
    tbl[8]  = '{4'b0000, 4'b0000, 0};
    tbl[9]  = '{4'b0011, 4'b0010, 1};
    tbl[10] = '{4'b1001, 4'b1000, 3};
    tbl[11] = '{4'b0100, 4'b0100, 2};

    @(posedge clk); #1;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);

    // Table-driven arbitration sequence, one full operation per entry.
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < N; i++) set_op(i, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      if (t == 0) set_op(0, 5'd16, 5'd16);
      req_valid = tbl[t].valid;
      rsp_ready = 1'b1;
      #1;
      chk("tbl_gnt", 32'(req_ready), 32'(tbl[t].exp_gnt));
      tick();
      if (tbl[t].exp_gnt != '0) begin
        req_valid = '0;
        #1;
        chk("tbl_calc_busy", 32'(busy), 32'd1);
        chk("tbl_calc_rsp_valid", 32'(rsp_valid), 32'd0);
        tick();
        chk("tbl_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("tbl_rsp_id", 32'(rsp_id), 32'(tbl[t].exp_id));
        if (t == 0) chk("first_rsp_data", 32'(rsp_data), 32'd5);
        tick();
        chk("tbl_back_idle", 32'(busy), 32'd0);
      end
    end

    // All four requesters continuously valid: 0,1,2,3,0 every 3 cycles.
    rst = 1'b1; req_valid = '0;
    tick();
    rst = 1'b0;
    gnt_log_id.delete(); gnt_log_cyc.delete();
    req_valid = 4'b1111; rsp_ready = 1'b1;
    repeat (16) tick();
    req_valid = '0;
    repeat (3) tick();
    if (gnt_log_id.size() < 5) begin
      n_cmp++; n_fail++;
      $display("FAIL cont_grants: got %0d grants expected at least 5", gnt_log_id.size());
    end else begin
      for (int g = 0; g < 5; g++) chk("cont_order", 32'(gnt_log_id[g]), 32'(g % 4));
      for (int g = 1; g < 5; g++) chk("cont_spacing", 32'(gnt_log_cyc[g] - gnt_log_cyc[g-1]), 32'd3);
    end

    // Backpressure: 5 stalled cycles in RESP with other requests pending.
    bp_a = 5'($urandom_range(0, 31)); bp_b = 5'($urandom_range(0, 31));
    set_op(2, bp_a, bp_b);
    req_valid = 4'b0100; rsp_ready = 1'b0;
    #1;
    chk("bp_gnt", 32'(req_ready), 32'b0100);
    tick();
    req_valid = 4'b1011;
    tick();
    for (int s = 0; s < 5; s++) begin
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_busy", 32'(busy), 32'd1);
      chk("bp_rsp_id", 32'(rsp_id), 32'd2);
      chk("bp_rsp_data", 32'(rsp_data), 32'(golden(bp_a, bp_b)));
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_release_idle", 32'(busy), 32'd0);
    chk("bp_next_gnt", 32'(req_ready), 32'b1000);
    tick();
    req_valid = '0;
    tick(); tick();

    // Reset during CALC, then during RESP.
    req_valid = 4'b0010; rsp_ready = 1'b1;
    tick();
    req_valid = '0; rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst_calc_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_calc_busy", 32'(busy), 32'd0);
    req_valid = 4'b1111;
    #1;
    chk("rst_calc_regrant", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0; rsp_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst_resp_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_resp_busy", 32'(busy), 32'd0);
    req_valid = 4'b1111;
    #1;
    chk("rst_resp_regrant", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0; rsp_ready = 1'b1;
    repeat (3) tick();

    // Random traffic with random response backpressure.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rsp_total = 0;
    guard = 0;
    while (rsp_total < 1000 && guard < 20000) begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && !last_gnt[i]) begin
          if ($urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
        end else begin
          req_valid[i] = 1'($urandom_range(0, 1));
          set_op(i, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end
      end
      rsp_ready = ($urandom_range(0, 2) != 0);
      tick();
      guard++;
    end
    if (rsp_total < 1000) begin
      n_cmp++; n_fail++;
      $display("FAIL rand_timeout: got %0d responses expected 1000", rsp_total);
    end
    req_valid = '0; rsp_ready = 1'b1;
    repeat (4) tick();
    chk("rand_sb_empty", 32'(sb_q.size()), 32'd0);
    for (int i = 0; i < N; i++) chk("rand_cnt_match", 32'(rsp_cnt[i]), 32'(grant_cnt[i]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
